// File: rtl/op_exec_pkg.sv
// Shared definitions for the opcode execution unit.
//   - default widths for the unit parameters
//   - opcode encodings (OP_NOP .. OP_ADD); any other code is illegal
//   - result_t: one output beat {data, addr, err} at the default widths
package op_exec_pkg;

  localparam int DATA_W_DEF = 32'sd32;
  localparam int ADDR_W_DEF = 32'sd3;
  localparam int OP_W_DEF   = 32'sd8;
  localparam int ERR_W_DEF  = 32'sd8;

  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_PASS = 8'h01;
  localparam logic [7:0] OP_SHR  = 8'h02;
  localparam logic [7:0] OP_SHL  = 8'h03;
  localparam logic [7:0] OP_INV  = 8'h04;
  localparam logic [7:0] OP_LOAD = 8'h05;
  localparam logic [7:0] OP_ADD  = 8'h06;

  typedef struct packed {
    logic [DATA_W_DEF-1:0] data;
    logic [ADDR_W_DEF-1:0] addr;
    logic                  err;
  } result_t;

endpackage

// File: rtl/op_exec_if.sv
// Command / result bus of the opcode execution unit.
//   in_valid/in_ready   : command handshake (in_op, in_addr, in_data)
//   out_valid/out_ready : result handshake (out_data, out_addr, out_err)
//   err_cnt             : saturating count of illegal opcodes
// master = command driver / result consumer, slave = the execution unit.
interface op_exec_if #(
  parameter int DATA_W = 32'sd32,
  parameter int ADDR_W = 32'sd3,
  parameter int OP_W   = 32'sd8,
  parameter int ERR_W  = 32'sd8
);
  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   in_op;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_addr;
  logic              out_err;
  logic [ERR_W-1:0]  err_cnt;

  modport master (
    output in_valid, in_op, in_addr, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_addr, out_err, err_cnt
  );

  modport slave (
    input  in_valid, in_op, in_addr, in_data, out_ready,
    output in_ready, out_valid, out_data, out_addr, out_err, err_cnt
  );
endinterface

// File: rtl/op_exec_regfile.sv
// Register file for the opcode execution unit.
//   clk, rst   : clock, asynchronous active-high clear of every entry
//   rd_addr_i  : combinational read address -> rd_data_o
//   wr_en_i    : synchronous write of wr_data_i into entry wr_addr_i
module op_exec_regfile #(
  parameter int DATA_W = 32'sd32,
  parameter int ADDR_W = 32'sd3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i
);
  localparam int DEPTH = 32'sd1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Storage array: cleared on reset, one write per clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {DATA_W{1'b0}};
      end
    end else if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Read port sees the value before the current edge's write.
  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/op_exec_unit.sv
// Opcode execution unit: decodes an accepted command, updates the
// addressed register and returns the result through one registered,
// back-pressurable output stage.
//   clk, rst : clock, asynchronous active-high reset
//   cmd      : op_exec_if.slave - command in, result out, err_cnt
module op_exec_unit
  import op_exec_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int OP_W   = OP_W_DEF,
  parameter int ERR_W  = ERR_W_DEF
) (
  input  logic      clk,
  input  logic      rst,
  op_exec_if.slave  cmd
);

  logic              accept_s;
  logic [DATA_W-1:0] rd_data_s;
  logic [DATA_W-1:0] exec_data_s;
  logic              exec_wr_s;
  logic              exec_err_s;
  logic              exec_emit_s;

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;
  logic [ADDR_W-1:0] out_addr_q,  out_addr_d;
  logic              out_err_q,   out_err_d;
  logic [ERR_W-1:0]  err_cnt_q,   err_cnt_d;

  // Single output slot: free when empty or being drained this cycle.
  assign cmd.in_ready = !out_valid_q || cmd.out_ready;
  assign accept_s     = cmd.in_valid && cmd.in_ready;

  op_exec_regfile #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .rd_addr_i (cmd.in_addr),
    .rd_data_o (rd_data_s),
    .wr_en_i   (accept_s && exec_wr_s),
    .wr_addr_i (cmd.in_addr),
    .wr_data_i (exec_data_s)
  );

  // Decode/execute of the presented command.
  always_comb begin
    exec_data_s = {DATA_W{1'b0}};
    exec_wr_s   = 1'b0;
    exec_err_s  = 1'b0;
    exec_emit_s = 1'b1;
    case (cmd.in_op)
      OP_W'(OP_NOP): begin
        exec_emit_s = 1'b0;
      end
      OP_W'(OP_PASS): begin
        exec_data_s = cmd.in_data;
        exec_wr_s   = 1'b1;
      end
      OP_W'(OP_SHR): begin
        exec_data_s = {1'b0, cmd.in_data[DATA_W-1:1]};
        exec_wr_s   = 1'b1;
      end
      OP_W'(OP_SHL): begin
        exec_data_s = {cmd.in_data[DATA_W-2:0], 1'b0};
        exec_wr_s   = 1'b1;
      end
      OP_W'(OP_INV): begin
        exec_data_s = ~cmd.in_data;
        exec_wr_s   = 1'b1;
      end
      OP_W'(OP_LOAD): begin
        exec_data_s = rd_data_s;
      end
      OP_W'(OP_ADD): begin
        exec_data_s = rd_data_s + cmd.in_data;
        exec_wr_s   = 1'b1;
      end
      default: begin
        exec_err_s = 1'b1;
      end
    endcase
  end

  // Next state of the output slot and the illegal-opcode counter.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_addr_d  = out_addr_q;
    out_err_d   = out_err_q;
    err_cnt_d   = err_cnt_q;

    // A new beat wins over a drain so a simultaneous drain+accept keeps valid high.
    if (accept_s && exec_emit_s) begin
      out_valid_d = 1'b1;
      out_data_d  = exec_data_s;
      out_addr_d  = cmd.in_addr;
      out_err_d   = exec_err_s;
    end else if (cmd.out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end

    if (accept_s && exec_err_s && (err_cnt_q != {ERR_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + {{(ERR_W-1){1'b0}}, 1'b1};
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // Output slot and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= {DATA_W{1'b0}};
      out_addr_q  <= {ADDR_W{1'b0}};
      out_err_q   <= 1'b0;
      err_cnt_q   <= {ERR_W{1'b0}};
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_addr_q  <= out_addr_d;
      out_err_q   <= out_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign cmd.out_valid = out_valid_q;
  assign cmd.out_data  = out_data_q;
  assign cmd.out_addr  = out_addr_q;
  assign cmd.out_err   = out_err_q;
  assign cmd.err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_op_exec_unit.sv
// Directed bench for op_exec_unit with a queue-based reference model.
module tb_op_exec_unit;
  import op_exec_pkg::*;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  op_exec_if #(.DATA_W(32), .ADDR_W(3), .OP_W(8), .ERR_W(8)) bus ();

  op_exec_unit #(.DATA_W(32), .ADDR_W(3), .OP_W(8), .ERR_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .cmd (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: register array, pending-beat queue, error count.
  logic [31:0] m_regs [8];
  result_t     m_q [$];
  int          m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) m_regs[i] = 32'h0;
      m_q.delete();
      m_err = 0;
    end else begin
      bit          slot_free;
      bit          legal;
      bit          wr;
      result_t     r;
      slot_free = (m_q.size() == 0) || bus.out_ready;
      if (m_q.size() > 0 && bus.out_ready) void'(m_q.pop_front());
      if (bus.in_valid && slot_free) begin
        r.addr = bus.in_addr;
        r.err  = 1'b0;
        r.data = 32'h0;
        legal  = 1'b1;
        wr     = 1'b1;
        case (int'(bus.in_op))
          1: r.data = bus.in_data;
          2: r.data = bus.in_data / 2;
          3: r.data = bus.in_data * 2;
          4: r.data = 32'hFFFF_FFFF - bus.in_data;
          5: begin r.data = m_regs[bus.in_addr]; wr = 1'b0; end
          6: r.data = m_regs[bus.in_addr] + bus.in_data;
          0: wr = 1'b0;
          default: begin legal = 1'b0; wr = 1'b0; r.err = 1'b1; end
        endcase
        if (wr) m_regs[bus.in_addr] = r.data;
        if (!legal && m_err < 255) m_err++;
        if (bus.in_op != 8'h00) m_q.push_back(r);
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("out_valid", {31'h0, bus.out_valid}, {31'h0, m_q.size() > 0});
    chk("in_ready", {31'h0, bus.in_ready}, {31'h0, (m_q.size() == 0) || bus.out_ready});
    chk("err_cnt", {24'h0, bus.err_cnt}, m_err[31:0]);
    if (m_q.size() > 0) begin
      chk("out_data", bus.out_data, m_q[0].data);
      chk("out_addr", {29'h0, bus.out_addr}, {29'h0, m_q[0].addr});
      chk("out_err", {31'h0, bus.out_err}, {31'h0, m_q[0].err});
    end
  end

  // Drive one command; returns #1 after the accepting edge.
  task automatic send(input logic [7:0] op, input logic [2:0] a, input logic [31:0] d);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_addr  = a;
    bus.in_data  = d;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 50) begin
      errors++;
      $display("FAIL send_timeout: in_ready stuck low for op %h", op);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic check_beat(input string name, input logic [31:0] d, input logic [2:0] a, input logic e);
    chk({name, "_valid"}, {31'h0, bus.out_valid}, 32'h1);
    chk({name, "_data"}, bus.out_data, d);
    chk({name, "_addr"}, {29'h0, bus.out_addr}, {29'h0, a});
    chk({name, "_err"}, {31'h0, bus.out_err}, {31'h0, e});
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    rst           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_op     = 8'h00;
    bus.in_addr   = 3'd0;
    bus.in_data   = 32'h0;
    bus.out_ready = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("rst_valid", {31'h0, bus.out_valid}, 32'h0);
    chk("rst_ready", {31'h0, bus.in_ready}, 32'h1);
    chk("rst_data", bus.out_data, 32'h0);
    chk("rst_errcnt", {24'h0, bus.err_cnt}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // PASS then LOAD on the same address
    send(8'h01, 3'd2, 32'h0000_00F0);
    check_beat("pass", 32'h0000_00F0, 3'd2, 1'b0);
    send(8'h05, 3'd2, 32'h0);
    check_beat("load2", 32'h0000_00F0, 3'd2, 1'b0);

    // Back-to-back shifts/invert on addr 0
    send(8'h02, 3'd0, 32'h8000_0001);
    check_beat("shr", 32'h4000_0000, 3'd0, 1'b0);
    send(8'h03, 3'd0, 32'h8000_0001);
    check_beat("shl", 32'h0000_0002, 3'd0, 1'b0);
    send(8'h04, 3'd0, 32'h0000_FFFF);
    check_beat("inv", 32'hFFFF_0000, 3'd0, 1'b0);
    send(8'h05, 3'd0, 32'h1234_5678);
    check_beat("load0", 32'hFFFF_0000, 3'd0, 1'b0);

    // ADD with wraparound
    send(8'h01, 3'd7, 32'hFFFF_FFFF);
    send(8'h06, 3'd7, 32'h0000_0002);
    check_beat("add_wrap", 32'h0000_0001, 3'd7, 1'b0);
    send(8'h05, 3'd7, 32'h0);
    check_beat("load7", 32'h0000_0001, 3'd7, 1'b0);

    // NOP drains the slot without producing a beat
    send(8'h00, 3'd7, 32'hDEAD_BEEF);
    chk("nop_valid", {31'h0, bus.out_valid}, 32'h0);

    // Backpressure: stall five cycles, then drain and accept on one edge
    bus.out_ready = 1'b0;
    send(8'h01, 3'd1, 32'h0000_0055);
    check_beat("bp_first", 32'h0000_0055, 3'd1, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_op    = 8'h01;
    bus.in_addr  = 3'd3;
    bus.in_data  = 32'h0000_00AA;
    for (int i = 0; i < 5; i++) begin
      chk("bp_in_ready", {31'h0, bus.in_ready}, 32'h0);
      check_beat("bp_hold", 32'h0000_0055, 3'd1, 1'b0);
      idle();
    end
    bus.out_ready = 1'b1;
    idle();
    bus.in_valid = 1'b0;
    check_beat("bp_next", 32'h0000_00AA, 3'd3, 1'b0);
    idle();
    chk("bp_drained", {31'h0, bus.out_valid}, 32'h0);

    // Illegal opcodes saturate the counter and leave registers alone
    for (int i = 0; i < 300; i++) begin
      send(8'h7F, 3'(i % 8), 32'hA5A5_0000 + 32'(i));
      check_beat("illegal", 32'h0, 3'(i % 8), 1'b1);
    end
    chk("err_sat", {24'h0, bus.err_cnt}, 32'h0000_00FF);
    send(8'h05, 3'd2, 32'h0);
    check_beat("keep2", 32'h0000_00F0, 3'd2, 1'b0);
    send(8'h05, 3'd0, 32'h0);
    check_beat("keep0", 32'hFFFF_0000, 3'd0, 1'b0);
    send(8'h05, 3'd7, 32'h0);
    check_beat("keep7", 32'h0000_0001, 3'd7, 1'b0);
    send(8'h05, 3'd1, 32'h0);
    check_beat("keep1", 32'h0000_0055, 3'd1, 1'b0);
    send(8'h05, 3'd3, 32'h0);
    check_beat("keep3", 32'h0000_00AA, 3'd3, 1'b0);
    send(8'h05, 3'd5, 32'h0);
    check_beat("keep5", 32'h0, 3'd5, 1'b0);

    // Asynchronous reset during a stall
    send(8'h01, 3'd4, 32'h0000_0123);
    bus.out_ready = 1'b0;
    check_beat("pre_rst", 32'h0000_0123, 3'd4, 1'b0);
    #1 rst = 1'b1;
    #1;
    chk("arst_valid", {31'h0, bus.out_valid}, 32'h0);
    chk("arst_data", bus.out_data, 32'h0);
    chk("arst_errcnt", {24'h0, bus.err_cnt}, 32'h0);
    chk("arst_ready", {31'h0, bus.in_ready}, 32'h1);
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    for (int a = 0; a < 8; a++) begin
      send(8'h05, 3'(a), 32'hFFFF_FFFF);
      check_beat("post_rst_load", 32'h0, 3'(a), 1'b0);
    end

    repeat (3) idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/op_exec_unit.md
# op_exec_unit

Parametrised opcode execution unit with an addressable register file and valid/ready handshakes on both sides. Each accepted command carries an opcode, a register address and a data word. The unit computes a result, optionally updates the addressed register, and returns the result through a registered, back-pressurable output stage. It sits between the command driver interface and downstream consumers, replacing the single-register, unhandshaked opcode processor.

## Interface
- `DATA_W`, 32, data and register width
- `ADDR_W`, 3, register address width; depth = 2**`ADDR_W`
- `OP_W`, 8, opcode width
- `ERR_W`, 8, width of the saturating error counter
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  command present
- `in_ready`  out  1  unit can accept a command this cycle
- `in_op`  in  `OP_W`  opcode
- `in_addr`  in  `ADDR_W`  register index
- `in_data`  in  `DATA_W`  operand
- `out_valid`  out  1  result present
- `out_ready`  in  1  consumer takes the result this cycle
- `out_data`  out  `DATA_W`  result
- `out_addr`  out  `ADDR_W`  register index of the originating command
- `out_err`  out  1  originating opcode was illegal
- `err_cnt`  out  `ERR_W`  saturating count of illegal opcodes

## Operation
- A command is accepted on a rising edge when `in_valid` && `in_ready`.
- The opcode set applies to accepted commands. R denotes reg[`in_addr`] before the edge.
  - 0 NOP: no register change, no output.
  - 1 PASS: result = `in_data`.
  - 2 SHR: result = `in_data` >> 1, logical.
  - 3 SHL: result = `in_data` << 1, MSB dropped.
  - 4 INV: result = ~`in_data`.
  - 5 LOAD: result = R. Register unchanged.
  - 6 ADD: result = R + `in_data` modulo 2**`DATA_W`. No carry out.
- Ops 1–4 and 6 write the result into reg[`in_addr`]. Op 5 does not write.
- Any other opcode:
  - result = 0 and `out_err` = 1;
  - no register write;
  - `err_cnt` increments and saturates at all-ones.
- Every accepted command except NOP produces exactly one output beat, in acceptance order.
- `out_data`, `out_addr` and `out_err` hold stable while `out_valid` && !`out_ready`.

## Timing
- Latency: a command accepted at edge N presents its result with `out_valid`=1 after edge N, i.e. during cycle N+1.
- `in_ready` = !`out_valid` || `out_ready`. This is a single output register with combinational pass-through of ready, and it sustains one command per cycle.
- Register writes commit at the acceptance edge. A LOAD or ADD accepted at edge N+1 on the same address sees the value written at edge N. No forwarding hazards.
- Same-cycle output drain and new accept: the output register reloads with the new result and `out_valid` stays 1.
- An accepted NOP with `out_ready`=1 drops `out_valid` to 0 if it was 1.
- Reset, asserted at any time, takes effect immediately without waiting for a clock edge:
  - `out_valid`=0, `out_data`=0, `out_addr`=0, `out_err`=0, `err_cnt`=0;
  - all registers = 0;
  - `in_ready` evaluates to 1.
  - A pending output is discarded.
- After reset deasserts, the first edge may accept a command.

## Structure
- Package `op_exec_pkg`: opcode localparams `OP_NOP`, `OP_PASS`, `OP_SHR`, `OP_SHL`, `OP_INV`, `OP_LOAD`, `OP_ADD`, and a `result_t` struct {data, addr, err}.
- One natural sub-module, `op_exec_regfile`: a 2**`ADDR_W` × `DATA_W` array with one combinational read port, one synchronous write port and asynchronous clear on `rst`.
- Top-level logic covers:
  - decode/execute (combinational);
  - handshake;
  - output register;
  - error counter.

## Test plan
- Reset, then PASS 0x0000_00F0 to addr 2, `out_ready`=1 → next cycle `out_data`=0x0000_00F0, `out_addr`=2, `out_err`=0. A following LOAD addr 2 returns 0x0000_00F0.
- Back-to-back SHR 0x8000_0001, SHL 0x8000_0001, INV 0x0000_FFFF to addr 0 → results 0x4000_0000, 0x0000_0002, 0xFFFF_0000 on consecutive cycles. LOAD addr 0 → 0xFFFF_0000.
- ADD accumulate: PASS 0xFFFF_FFFF to addr 7, then ADD 2 to addr 7 → `out_data`=0x0000_0001 (wrap). LOAD 7 → 0x0000_0001.
- Backpressure: hold `out_ready`=0 after one accepted PASS 0x55 → `in_ready`=0 and the output stays 0x55 for 5 cycles. Release → the queued next command is accepted on the same edge as the drain, with no loss or duplication.
- Illegal opcode 0x7F ×300 → each beat has `out_err`=1, `out_data`=0. `err_cnt` saturates at 0xFF and the register file is unchanged.
- Assert `rst` mid-stall with `out_valid`=1 → `out_valid` drops without a clock edge. A LOAD on any address afterward returns 0.
